nn_grad_accum: RTL
==================

Name: nn_grad_accum

Overview:
- Producer side of the weight add/subtract interface.
- Accumulates stochastic error/activation bitstream coincidences over a programmable window.
- Forms the signed net gradient and presents its magnitude as `arg` and its sign as `OPERATION`, with a VALID/ACK handshake, to the saturating weight/bias updater.
- One instance per weight or bias in the NN training datapath.

Parameters:
- Narg, 16, width of the positive/negative counters and of `arg` (matches updater `arg` width).
- Nwin, 10, width of the window-length input and window counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- EN  input  1  run enable; high starts and continues accumulation windows.
- win_len  input  Nwin  window length in cycles; 0 is treated as 1; sampled on entry to ACCUM.
- err_pos  input  1  positive-error stochastic stream.
- err_neg  input  1  negative-error stochastic stream.
- act  input  1  activation stochastic stream (1 for bias instances).
- arg  output  Narg  gradient magnitude to the updater.
- OPERATION  output  1  0 = add (pos ≥ neg), 1 = subtract (neg > pos).
- VALID  output  1  `arg`/`OPERATION` valid.
- ACK  input  1  updater accepts on a cycle with VALID & ACK.
- BUSY  output  1  high in any state except IDLE.
- ovf  output  1  sticky: a counter saturated in the current window.

Behaviour:
- Reset (async, RST_n low): state IDLE; arg=0, OPERATION=0, VALID=0, BUSY=0, ovf=0; counters and window counter cleared.
- IDLE:
  - EN=1 → ACCUM; pos_cnt, neg_cnt, win_cnt and ovf cleared; win_len latched.
- ACCUM:
  - Each cycle, pos_cnt += (err_pos & act) and neg_cnt += (err_neg & act); both may increment in the same cycle.
  - Counters saturate at 2^Narg−1; any saturation sets ovf (held until the next ACCUM entry).
  - win_cnt increments each cycle. After exactly max(win_len,1) sampled cycles → CALC.
  - EN low during ACCUM aborts → IDLE; counters are discarded and nothing is issued.
- CALC (1 cycle, inputs ignored):
  - pos_cnt ≥ neg_cnt: register arg = pos_cnt − neg_cnt, OPERATION = 0.
  - Otherwise: arg = neg_cnt − pos_cnt, OPERATION = 1.
  - Subtraction is unsigned in Narg bits and never underflows. → ISSUE.
- ISSUE:
  - VALID=1; arg and OPERATION held stable until the transfer cycle (VALID & ACK).
  - On transfer, VALID drops on the next edge. Then: EN=1 → ACCUM (counters cleared, win_len re-latched); EN=0 → IDLE.
  - EN deassertion during ISSUE does not cancel the pending transfer.
  - err_*/act are ignored in ISSUE (samples dropped; no back-pressure to the streams).
- Latency: VALID rises on the 2nd edge after the last ACCUM sample. With ACK tied high, the minimum period is win_len + 2 cycles.
- arg and OPERATION keep their last issued values outside ISSUE. VALID is never high outside ISSUE.
- ACK while VALID=0 is ignored.
- Reset asserted mid-window or mid-ISSUE: immediate return to reset values; a pending transfer is lost.

Optional Feature:
- Macro: NN_GRAD_ZERO_SKIP_EN.
- Defined: when the CALC difference is 0, ISSUE is skipped. Next state is ACCUM if EN=1, otherwise IDLE. VALID stays 0; arg/OPERATION are not updated.
- Undefined: zero-difference results are issued normally with arg=0, OPERATION=0.

Test Plan:
- Basic add: win_len=8, EN=1, act=1, err_pos=1 all 8 cycles, err_neg=1 for 3 → VALID with arg=5, OPERATION=0; VALID 2 edges after the last sample; ACK=1 → next window starts.
- Basic subtract: win_len=8, err_pos high 2 cycles, err_neg high 6 cycles, act=1 → arg=4, OPERATION=1.
- Act gating and saturation (Narg=4): win_len=20, err_pos=1, act=1 for first 10 cycles then 0 → arg=10, ovf=0. Repeat with act=1 throughout → arg=15, ovf=1.
- Back-pressure: ACK held low 5 cycles after VALID → VALID, arg, OPERATION stable for all 5; err_pos toggling ignored; single transfer on ACK, then VALID=0.
- Abort/reset: EN dropped at cycle 4 of an 8-cycle window → IDLE, no VALID. RST_n pulsed low while VALID=1 → all outputs 0 immediately, BUSY=0.
- Zero result: equal pos/neg counts of 4 → with NN_GRAD_ZERO_SKIP_EN defined, no VALID and the next window starts. Without it, VALID with arg=0, OPERATION=0.

Source files
------------

// File: rtl/nn_grad_accum.sv
// rtl/nn_grad_accum.sv - stochastic error/activation gradient accumulator feeding the weight updater
//
// Counts coincidences of the error streams with the activation stream over a
// programmable window, then offers the signed net gradient (magnitude + sign)
// to the saturating weight/bias updater over a VALID/ACK handshake.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_n      asynchronous active-low reset
//   EN         run enable; starts and continues accumulation windows
//   win_len    window length in cycles (0 behaves as 1), latched on window entry
//   err_pos    positive-error stochastic stream
//   err_neg    negative-error stochastic stream
//   act        activation stochastic stream (tied 1 for bias instances)
//   arg        gradient magnitude to the updater
//   OPERATION  0 = add (pos >= neg), 1 = subtract (neg > pos)
//   VALID      arg/OPERATION valid
//   ACK        updater accepts on a cycle with VALID & ACK
//   BUSY       high in any state except IDLE
//   ovf        sticky: a counter saturated in the current window
//
// Build option: NN_GRAD_ZERO_SKIP_EN - when defined, a zero net gradient is not
// issued; the block moves straight on to the next window (or IDLE).

module nn_grad_accum #(
    parameter int Narg = 16,
    parameter int Nwin = 10
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            EN,
    input  logic [Nwin-1:0] win_len,
    input  logic            err_pos,
    input  logic            err_neg,
    input  logic            act,
    output logic [Narg-1:0] arg,
    output logic            OPERATION,
    output logic            VALID,
    input  logic            ACK,
    output logic            BUSY,
    output logic            ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_CALC,
        S_ISSUE
    } state_t;

    state_t          state;
    logic [Narg-1:0] pos_cnt;
    logic [Narg-1:0] neg_cnt;
    logic [Nwin-1:0] win_cnt;
    logic [Nwin-1:0] win_tgt;

    logic [Nwin-1:0] win_eff;
    logic [Narg-1:0] pos_next;
    logic [Narg-1:0] neg_next;
    logic            pos_sat;
    logic            neg_sat;
    logic            pos_ge;
    logic [Narg-1:0] diff;

    assign win_eff = (win_len == '0) ? Nwin'(1) : win_len;

    // Saturating increments; a dropped count (counter already full) flags ovf.
    always_comb begin
        pos_next = pos_cnt;
        neg_next = neg_cnt;
        pos_sat  = 1'b0;
        neg_sat  = 1'b0;
        if (err_pos && act) begin
            if (&pos_cnt) pos_sat  = 1'b1;
            else          pos_next = pos_cnt + Narg'(1);
        end
        if (err_neg && act) begin
            if (&neg_cnt) neg_sat  = 1'b1;
            else          neg_next = neg_cnt + Narg'(1);
        end
    end

    // Larger minus smaller, so the unsigned difference never wraps.
    assign pos_ge = (pos_cnt >= neg_cnt);
    assign diff   = pos_ge ? (pos_cnt - neg_cnt) : (neg_cnt - pos_cnt);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= S_IDLE;
            pos_cnt   <= '0;
            neg_cnt   <= '0;
            win_cnt   <= '0;
            win_tgt   <= '0;
            arg       <= '0;
            OPERATION <= 1'b0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (EN) begin
                        state   <= S_ACCUM;
                        BUSY    <= 1'b1;
                        pos_cnt <= '0;
                        neg_cnt <= '0;
                        win_cnt <= '0;
                        ovf     <= 1'b0;
                        win_tgt <= win_eff;
                    end
                end

                S_ACCUM: begin
                    if (!EN) begin
                        // Abort: partial counts are simply abandoned.
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        pos_cnt <= pos_next;
                        neg_cnt <= neg_next;
                        if (pos_sat || neg_sat) ovf <= 1'b1;
                        win_cnt <= win_cnt + Nwin'(1);
                        if (win_cnt == win_tgt - Nwin'(1)) state <= S_CALC;
                    end
                end

                S_CALC: begin
`ifdef NN_GRAD_ZERO_SKIP_EN
                    if (diff == '0) begin
                        if (EN) begin
                            state   <= S_ACCUM;
                            pos_cnt <= '0;
                            neg_cnt <= '0;
                            win_cnt <= '0;
                            ovf     <= 1'b0;
                            win_tgt <= win_eff;
                        end else begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        arg       <= diff;
                        OPERATION <= ~pos_ge;
                        VALID     <= 1'b1;
                        state     <= S_ISSUE;
                    end
`else
                    arg       <= diff;
                    OPERATION <= ~pos_ge;
                    VALID     <= 1'b1;
                    state     <= S_ISSUE;
`endif
                end

                S_ISSUE: begin
                    if (ACK) begin
                        VALID <= 1'b0;
                        if (EN) begin
                            state   <= S_ACCUM;
                            pos_cnt <= '0;
                            neg_cnt <= '0;
                            win_cnt <= '0;
                            ovf     <= 1'b0;
                            win_tgt <= win_eff;
                        end else begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
